// File: rtl/polaris_bus_arbiter.sv
// polaris_bus_arbiter
// Merges the PolarisCPU instruction (I) and data (D) master ports onto one
// shared 64-bit bus master port. One requester is granted at a time; the
// grant is held until the slave acknowledges, and ack/read data are steered
// back to the granted side combinationally. Every grant is followed by one
// IDLE cycle, and simultaneous requests alternate via the last-served flag.
//
// Optional feature macro: POLARIS_ARB_WATCHDOG_EN
//   Defined   - a 16-bit grant watchdog forces a completion (ack with zero
//               data plus a berr_o pulse) after TMO_CYCLES granted cycles
//               without back_i.
//   Undefined - no watchdog, berr_o tied 0, a grant waits indefinitely.
module polaris_bus_arbiter #(
    parameter int ABW        = 64,
    parameter int TMO_CYCLES = 255
) (
    input  logic           clk_i,
    input  logic           reset_i,
    input  logic [ABW-1:0] iadr_i,
    input  logic [1:0]     isiz_i,
    output logic           iack_o,
    output logic [31:0]    idat_o,
    input  logic [ABW-1:0] dadr_i,
    input  logic [63:0]    ddat_i,
    input  logic           dwe_i,
    input  logic           dcyc_i,
    input  logic           dstb_i,
    input  logic [1:0]     dsiz_i,
    input  logic           dsigned_i,
    output logic           dack_o,
    output logic [63:0]    ddat_o,
    output logic [ABW-1:0] badr_o,
    output logic [63:0]    bdat_o,
    input  logic [63:0]    bdat_i,
    output logic           bwe_o,
    output logic           bcyc_o,
    output logic           bstb_o,
    output logic [1:0]     bsiz_o,
    output logic           bsigned_o,
    input  logic           back_i,
    output logic           berr_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } state_t;

    state_t state_r;
    state_t state_nxt_s;
    logic   last_d_r;
    logic   last_d_nxt_s;
    logic   ireq_s;
    logic   dreq_s;
    logic   expire_s;

    assign ireq_s = |isiz_i;
    assign dreq_s = dcyc_i & dstb_i;

`ifdef POLARIS_ARB_WATCHDOG_EN
    // Expiry fires in the granted cycle whose count equals TMO_CYCLES.
    localparam logic [15:0] TMO_LAST = 16'(TMO_CYCLES - 1);

    logic [15:0] wdog_r;

    // Grant watchdog: zero while idle (so every grant starts from 0), counts granted cycles without ack.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wdog_r <= 16'd0;
        end else if (state_r == IDLE) begin
            wdog_r <= 16'd0;
        end else if (!back_i) begin
            wdog_r <= wdog_r + 16'd1;
        end else begin
            wdog_r <= wdog_r;
        end
    end

    assign expire_s = (state_r != IDLE) && (wdog_r == TMO_LAST);
`else
    logic unused_tmo;

    assign expire_s   = 1'b0;
    assign unused_tmo = (TMO_CYCLES != 0);
`endif

    // Grant state and last-served flag registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r  <= IDLE;
            last_d_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            last_d_r <= last_d_nxt_s;
        end
    end

    // Arbitration and grant-completion decisions.
    always_comb begin
        state_nxt_s  = state_r;
        last_d_nxt_s = last_d_r;
        case (state_r)
            IDLE: begin
                if (ireq_s && dreq_s) begin
                    state_nxt_s = last_d_r ? IGNT : DGNT;
                end else if (dreq_s) begin
                    state_nxt_s = DGNT;
                end else if (ireq_s) begin
                    state_nxt_s = IGNT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            IGNT: begin
                if (back_i || expire_s) begin
                    state_nxt_s  = IDLE;
                    last_d_nxt_s = 1'b0;
                end else if (!ireq_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = IGNT;
                end
            end
            DGNT: begin
                if (back_i || expire_s) begin
                    state_nxt_s  = IDLE;
                    last_d_nxt_s = 1'b1;
                end else if (!dreq_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DGNT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Bus drive and ack/data steering for the granted side; everything 0 when idle.
    always_comb begin
        badr_o    = '0;
        bdat_o    = 64'd0;
        bwe_o     = 1'b0;
        bcyc_o    = 1'b0;
        bstb_o    = 1'b0;
        bsiz_o    = 2'b00;
        bsigned_o = 1'b0;
        iack_o    = 1'b0;
        idat_o    = 32'd0;
        dack_o    = 1'b0;
        ddat_o    = 64'd0;
        berr_o    = expire_s & ~back_i;
        case (state_r)
            IGNT: begin
                badr_o = iadr_i;
                bsiz_o = isiz_i;
                bcyc_o = 1'b1;
                bstb_o = 1'b1;
                iack_o = back_i | expire_s;
                if (back_i) begin
                    idat_o = iadr_i[2] ? bdat_i[63:32] : bdat_i[31:0];
                end else begin
                    idat_o = 32'd0;
                end
            end
            DGNT: begin
                badr_o    = dadr_i;
                bdat_o    = ddat_i;
                bwe_o     = dwe_i;
                bsiz_o    = dsiz_i;
                bsigned_o = dsigned_i;
                bcyc_o    = 1'b1;
                bstb_o    = 1'b1;
                dack_o    = back_i | expire_s;
                if (back_i) begin
                    ddat_o = bdat_i;
                end else begin
                    ddat_o = 64'd0;
                end
            end
            default: begin
                berr_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_polaris_bus_arbiter.sv
// Self-checking bench for polaris_bus_arbiter: directed scenarios followed by
// randomized traffic, every cycle compared against a transaction-level model
// that tracks which master owns the bus and for how many cycles.
// Honours POLARIS_ARB_WATCHDOG_EN (watchdog limit set to 8 when defined).
module tb_polaris_bus_arbiter;

`ifdef POLARIS_ARB_WATCHDOG_EN
    localparam int TMO = 8;
    localparam bit WD_EN = 1'b1;
`else
    localparam int TMO = 255;
    localparam bit WD_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [63:0] iadr_i;
    logic [1:0]  isiz_i;
    logic        iack_o;
    logic [31:0] idat_o;
    logic [63:0] dadr_i;
    logic [63:0] ddat_i;
    logic        dwe_i, dcyc_i, dstb_i, dsigned_i;
    logic [1:0]  dsiz_i;
    logic        dack_o;
    logic [63:0] ddat_o;
    logic [63:0] badr_o, bdat_o, bdat_i;
    logic        bwe_o, bcyc_o, bstb_o, bsigned_o, back_i, berr_o;
    logic [1:0]  bsiz_o;

    int checks = 0;
    int errors = 0;

    // Reference model: owner 0 = nobody, 1 = I port, 2 = D port.
    int owner  = 0;
    bit last_d = 1'b0;
    int gcyc   = 0;
    bit m_iack, m_dack;
    bit ipend, dpend;

    polaris_bus_arbiter #(.ABW(64), .TMO_CYCLES(TMO)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .iadr_i(iadr_i), .isiz_i(isiz_i), .iack_o(iack_o), .idat_o(idat_o),
        .dadr_i(dadr_i), .ddat_i(ddat_i), .dwe_i(dwe_i), .dcyc_i(dcyc_i),
        .dstb_i(dstb_i), .dsiz_i(dsiz_i), .dsigned_i(dsigned_i),
        .dack_o(dack_o), .ddat_o(ddat_o),
        .badr_o(badr_o), .bdat_o(bdat_o), .bdat_i(bdat_i), .bwe_o(bwe_o),
        .bcyc_o(bcyc_o), .bstb_o(bstb_o), .bsiz_o(bsiz_o),
        .bsigned_o(bsigned_o), .back_i(back_i), .berr_o(berr_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Compare every output against the model, then advance the model.
    task automatic step();
        bit          to, ir, dr;
        logic [63:0] e_badr, e_bdat, e_ddat;
        logic [31:0] e_idat;
        logic [1:0]  e_bsiz;
        bit          e_bwe, e_bcs, e_bsg, e_berr;
        @(negedge clk_i);
        to = WD_EN && (owner != 0) && (gcyc == TMO);
        e_badr = 64'd0; e_bdat = 64'd0; e_ddat = 64'd0; e_idat = 32'd0;
        e_bsiz = 2'b00; e_bwe = 1'b0; e_bcs = 1'b0; e_bsg = 1'b0;
        m_iack = 1'b0; m_dack = 1'b0;
        e_berr = to && !back_i;
        if (owner == 1) begin
            e_badr = iadr_i; e_bsiz = isiz_i; e_bcs = 1'b1;
            m_iack = back_i || to;
            if (back_i) e_idat = iadr_i[2] ? bdat_i[63:32] : bdat_i[31:0];
        end else if (owner == 2) begin
            e_badr = dadr_i; e_bdat = ddat_i; e_bwe = dwe_i; e_bsiz = dsiz_i;
            e_bsg = dsigned_i; e_bcs = 1'b1;
            m_dack = back_i || to;
            if (back_i) e_ddat = bdat_i;
        end
        check_val("badr", badr_o, e_badr);
        check_val("bdat", bdat_o, e_bdat);
        check_val("bwe", {63'd0, bwe_o}, {63'd0, e_bwe});
        check_val("bcyc", {63'd0, bcyc_o}, {63'd0, e_bcs});
        check_val("bstb", {63'd0, bstb_o}, {63'd0, e_bcs});
        check_val("bsiz", {62'd0, bsiz_o}, {62'd0, e_bsiz});
        check_val("bsigned", {63'd0, bsigned_o}, {63'd0, e_bsg});
        check_val("iack", {63'd0, iack_o}, {63'd0, m_iack});
        check_val("idat", {32'd0, idat_o}, {32'd0, e_idat});
        check_val("dack", {63'd0, dack_o}, {63'd0, m_dack});
        check_val("ddat", ddat_o, e_ddat);
        check_val("berr", {63'd0, berr_o}, {63'd0, e_berr});
        ir = (isiz_i != 2'b00);
        dr = dcyc_i && dstb_i;
        if (reset_i) begin
            owner = 0; last_d = 1'b0; gcyc = 0;
        end else if (owner == 0) begin
            if (ir && dr) owner = last_d ? 1 : 2;
            else if (dr)  owner = 2;
            else if (ir)  owner = 1;
            gcyc = (owner != 0) ? 1 : 0;
        end else if (back_i || to) begin
            last_d = (owner == 2);
            owner = 0; gcyc = 0;
        end else if ((owner == 1 && !ir) || (owner == 2 && !dr)) begin
            owner = 0; gcyc = 0;
        end else begin
            gcyc++;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        iadr_i = 64'd0; isiz_i = 2'b00; dadr_i = 64'd0; ddat_i = 64'd0;
        dwe_i = 1'b0; dcyc_i = 1'b0; dstb_i = 1'b0; dsiz_i = 2'b00;
        dsigned_i = 1'b0; back_i = 1'b0; bdat_i = 64'd0;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
    endtask

    initial begin
        reset_i = 1'b1;
        idle_inputs();
        @(posedge clk_i);
        #1;
        do_reset();

        // I fetch, acked on the third granted cycle, upper word selected by iadr[2].
        iadr_i = 64'h1004; isiz_i = 2'b10;
        step(); step(); step();
        back_i = 1'b1; bdat_i = 64'hAAAA_BBBB_CCCC_DDDD;
        #1;
        check_val("t1_iack", {63'd0, iack_o}, 64'd1);
        check_val("t1_idat", {32'd0, idat_o}, 64'hAAAA_BBBB);
        check_val("t1_badr", badr_o, 64'h1004);
        check_val("t1_bwe", {63'd0, bwe_o}, 64'd0);
        step();
        idle_inputs();
        step();

        // D store acked on the first granted cycle.
        dcyc_i = 1'b1; dstb_i = 1'b1; dwe_i = 1'b1; dadr_i = 64'h2000;
        ddat_i = 64'h1234; dsiz_i = 2'b11;
        step();
        back_i = 1'b1;
        #1;
        check_val("t2_bwe", {63'd0, bwe_o}, 64'd1);
        check_val("t2_bdat", bdat_o, 64'h1234);
        check_val("t2_dack", {63'd0, dack_o}, 64'd1);
        check_val("t2_iack", {63'd0, iack_o}, 64'd0);
        step();
        idle_inputs();
        step();

        // Continuous contention: D, idle, I, idle, ... starting with D.
        do_reset();
        iadr_i = 64'h40; isiz_i = 2'b01; dcyc_i = 1'b1; dstb_i = 1'b1;
        dadr_i = 64'h80; back_i = 1'b1; bdat_i = 64'h0123_4567_89AB_CDEF;
        for (int k = 0; k < 8; k++) begin
            #1;
            check_val("t3_dack", {63'd0, dack_o}, {63'd0, (k % 4) == 1});
            check_val("t3_iack", {63'd0, iack_o}, {63'd0, (k % 4) == 3});
            step();
        end
        idle_inputs();
        step();

        // Reset in the second granted cycle of a pending D access.
        do_reset();
        dcyc_i = 1'b1; dstb_i = 1'b1; dadr_i = 64'h3000;
        step(); step();
        reset_i = 1'b1;
        step();
        reset_i = 1'b0; back_i = 1'b1; bdat_i = 64'hFFFF;
        #1;
        check_val("t4_bcyc", {63'd0, bcyc_o}, 64'd0);
        check_val("t4_dack", {63'd0, dack_o}, 64'd0);
        step();
        idle_inputs();
        step();

`ifdef POLARIS_ARB_WATCHDOG_EN
        // Watchdog expiry on the 8th granted cycle, then a normal ack on cycle 8.
        do_reset();
        iadr_i = 64'h8; isiz_i = 2'b01; bdat_i = 64'h5555_6666_7777_8888;
        step();
        for (int g = 1; g <= 8; g++) begin
            #1;
            check_val("wd_iack", {63'd0, iack_o}, {63'd0, g == 8});
            check_val("wd_berr", {63'd0, berr_o}, {63'd0, g == 8});
            if (g == 8) check_val("wd_idat", {32'd0, idat_o}, 64'd0);
            step();
        end
        isiz_i = 2'b00;
        #1;
        check_val("wd_idle", {63'd0, bcyc_o}, 64'd0);
        step();
        isiz_i = 2'b01;
        step();
        for (int g = 1; g <= 8; g++) begin
            back_i = (g == 8);
            #1;
            check_val("wd2_iack", {63'd0, iack_o}, {63'd0, g == 8});
            check_val("wd2_berr", {63'd0, berr_o}, 64'd0);
            step();
        end
        idle_inputs();
        step();
`endif

        // Randomized traffic against the model.
        ipend = 1'b0; dpend = 1'b0;
        m_iack = 1'b0; m_dack = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (m_iack) begin ipend = 1'b0; isiz_i = 2'b00; end
            if (m_dack) begin dpend = 1'b0; dcyc_i = 1'b0; dstb_i = 1'b0; end
            if (!ipend && $urandom_range(0, 1) == 0) begin
                ipend = 1'b1;
                iadr_i = {$urandom, $urandom};
                isiz_i = 2'($urandom_range(1, 3));
            end else if (ipend && $urandom_range(0, 63) == 0) begin
                ipend = 1'b0; isiz_i = 2'b00;
            end
            if (!dpend && $urandom_range(0, 1) == 0) begin
                dpend = 1'b1;
                dadr_i = {$urandom, $urandom}; ddat_i = {$urandom, $urandom};
                dwe_i = 1'($urandom); dsiz_i = 2'($urandom); dsigned_i = 1'($urandom);
                dcyc_i = 1'b1; dstb_i = 1'b1;
            end else if (dpend && $urandom_range(0, 63) == 0) begin
                dpend = 1'b0; dstb_i = 1'b0;
            end else if (!dpend) begin
                dcyc_i = 1'($urandom); dstb_i = 1'b0;
            end
            back_i = ($urandom_range(0, 2) == 0);
            bdat_i = {$urandom, $urandom};
            reset_i = ($urandom_range(0, 199) == 0);
            step();
        end
        reset_i = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/polaris_bus_arbiter.md
Name: polaris_bus_arbiter

Overview:
- Merges the PolarisCPU instruction (I) and data (D) master ports onto one shared 64-bit external bus master port.
- Sits between the CPU and the memory/peripheral fabric.
- Grants one requester at a time, holds the grant until the slave acknowledges, and steers the acknowledge and read data back to the granted side.
- Both CPU ports remain unmodified.

Parameters:
- ABW, 64, address width of I, D and bus ports.
- TMO_CYCLES, 255, watchdog limit in cycles (used only with the optional feature); range 1..65535.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset; synchronous, active-high.
- iadr_i  in  ABW  CPU fetch address.
- isiz_i  in  2  CPU fetch size; nonzero = fetch request.
- iack_o  out  1  fetch acknowledge to CPU.
- idat_o  out  32  fetched instruction.
- dadr_i  in  ABW  CPU data address.
- ddat_i  in  64  CPU write data.
- dwe_i  in  1  CPU write enable.
- dcyc_i  in  1  CPU data cycle.
- dstb_i  in  1  CPU data strobe.
- dsiz_i  in  2  CPU data size.
- dsigned_i  in  1  CPU sign-extend request.
- dack_o  out  1  data acknowledge to CPU.
- ddat_o  out  64  read data to CPU.
- badr_o  out  ABW  bus address.
- bdat_o  out  64  bus write data.
- bdat_i  in  64  bus read data.
- bwe_o  out  1  bus write enable.
- bcyc_o  out  1  bus cycle.
- bstb_o  out  1  bus strobe.
- bsiz_o  out  2  bus size.
- bsigned_o  out  1  bus sign-extend.
- back_i  in  1  bus acknowledge.
- berr_o  out  1  watchdog expiry pulse (tied 0 without the feature).

Behaviour:
- Requests:
  - ireq = |isiz_i.
  - dreq = dcyc_i & dstb_i.
  - Both masters hold their request stable until acknowledged.
- States: IDLE, IGNT, DGNT. Reset → IDLE, last-served flag `last_d` = 0.
- Reset values:
  - All outputs 0.
  - Reset mid-transfer drops bcyc_o/bstb_o the next cycle; any back_i arriving in that cycle is ignored.
- IDLE transitions:
  - dreq only → DGNT.
  - ireq only → IGNT.
  - Both asserted → the side not last served (`last_d`=1 → IGNT, else DGNT).
  - Neither → stay.
- Decision latency: request seen at edge N, bus driven during cycle N+1.
- IGNT bus drive:
  - badr_o = iadr_i, bsiz_o = isiz_i.
  - bwe_o = 0, bsigned_o = 0, bcyc_o = bstb_o = 1.
  - bdat_o = 0.
- DGNT bus drive:
  - All bus signals mirror the D inputs.
  - bcyc_o = bstb_o = 1.
- Non-granted port: ack 0, data 0.
- In IDLE, bus outputs are all 0.
- Acknowledge steering (combinational pass-through, zero added latency):
  - iack_o = back_i & IGNT.
  - dack_o = back_i & DGNT.
- Read data:
  - idat_o = iadr_i[2] ? bdat_i[63:32] : bdat_i[31:0] while IGNT & back_i, else 0.
  - ddat_o = bdat_i while DGNT & back_i, else 0.
- On back_i in a grant state:
  - Return to IDLE.
  - Set `last_d` = 1 if the completed grant was DGNT, else 0.
  - The state always passes through IDLE, giving one idle bus cycle between transfers.
- Request withdrawn while granted (protocol violation): return to IDLE next edge; no ack is generated.
- back_i while IDLE: ignored.

Optional Feature:
- POLARIS_ARB_WATCHDOG_EN
- Defined:
  - A 16-bit counter clears on entering IGNT/DGNT and increments each cycle without back_i.
  - When it reaches TMO_CYCLES, the granted port's ack is forced high for one cycle with data 0, berr_o pulses 1 for that cycle, and the state returns to IDLE.
  - `last_d` updates as for a normal completion.
  - A back_i arriving in the expiry cycle counts as a normal completion, and berr_o stays 0.
- Undefined: no counter, berr_o is tied 0, and a grant waits indefinitely.

Test Plan:
- Reset, then isiz_i=2'b10, iadr_i=0x1004; bus acks 2 cycles after bstb_o with bdat_i=0xAAAA_BBBB_CCCC_DDDD → iack_o=1 for one cycle with idat_o=0xAAAA_BBBB; badr_o=0x1004, bwe_o=0.
- D store: dcyc/dstb=1, dwe=1, dadr=0x2000, ddat=0x1234, dsiz=2'b11; ack on the first granted cycle → bwe_o=1, bdat_o=0x1234, dack_o=1, iack_o=0.
- ireq and dreq both asserted continuously, with the slave acking each granted cycle immediately → grants alternate D,I,D,I starting with D after reset, with an IDLE cycle between each.
- reset_i asserted in the second cycle of a DGNT waiting for ack → bcyc_o=0 the following cycle; back_i=1 in that cycle gives dack_o=0.
- POLARIS_ARB_WATCHDOG_EN defined, TMO_CYCLES=8, I fetch with back_i held 0 → on the 8th granted cycle iack_o=1, idat_o=0, berr_o=1 for one cycle, then state IDLE.
- Same setup, back_i=1 on granted cycle 8 → normal completion, berr_o=0.
